// File: rtl/pipeline_stall_ctrl.sv
// rtl/pipeline_stall_ctrl.sv - IF/ID register owner with load-use stall, branch flush and dmem freeze control
module pipeline_stall_ctrl #(
  parameter int          FLUSH_CYCLES = 1,
  parameter int          CNT_W        = 16,
  parameter logic [31:0] NOP_WORD     = 32'h00000000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             hazard,
  input  logic             branch_taken,
  input  logic             dmem_busy,
  input  logic [31:0]      IF_pc,
  input  logic [31:0]      IF_order,
  output logic             PC_write,
  output logic             IDEX_bubble,
  output logic             EXMEM_hold,
  output logic [31:0]      ID_pc,
  output logic [31:0]      ID_order,
  output logic             ID_valid,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic {RUN, FLUSH} state_t;

  localparam logic [3:0]       SQ_INIT = 4'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t     state, state_nxt;
  logic [3:0] sq, sq_nxt;
  logic       do_squash, do_stall, do_load;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= RUN;
      sq          <= 4'd0;
      ID_pc       <= 32'd0;
      ID_order    <= NOP_WORD;
      ID_valid    <= 1'b0;
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      state <= state_nxt;
      sq    <= sq_nxt;
      if (do_squash) begin
        ID_pc       <= 32'd0;
        ID_order    <= NOP_WORD;
        ID_valid    <= 1'b0;
        flush_count <= (flush_count == CNT_MAX) ? flush_count : flush_count + 1'b1;
      end else if (do_stall) begin
        stall_count <= (stall_count == CNT_MAX) ? stall_count : stall_count + 1'b1;
      end else if (do_load) begin
        ID_pc    <= IF_pc;
        ID_order <= IF_order;
        ID_valid <= 1'b1;
      end
    end
  end

  // Priority: reset > dmem_busy > branch_taken > flush in progress > hazard > normal
  always_comb begin
    state_nxt   = state;
    sq_nxt      = sq;
    PC_write    = 1'b1;
    IDEX_bubble = 1'b0;
    EXMEM_hold  = 1'b0;
    do_squash   = 1'b0;
    do_stall    = 1'b0;
    do_load     = 1'b0;
    if (reset) begin
      PC_write    = 1'b0;
      IDEX_bubble = 1'b1;
    end else if (dmem_busy) begin
      PC_write   = 1'b0;
      EXMEM_hold = 1'b1;
    end else if (branch_taken) begin
      IDEX_bubble = 1'b1;
      do_squash   = 1'b1;
      if (FLUSH_CYCLES > 1) begin
        state_nxt = FLUSH;
        sq_nxt    = SQ_INIT;
      end else begin
        state_nxt = RUN;
        sq_nxt    = 4'd0;
      end
    end else if (state == FLUSH) begin
      IDEX_bubble = 1'b1;
      do_squash   = 1'b1;
      sq_nxt      = sq - 4'd1;
      if (sq == 4'd1) begin
        state_nxt = RUN;
      end
    end else if (hazard) begin
      PC_write    = 1'b0;
      IDEX_bubble = 1'b1;
      do_stall    = 1'b1;
    end else begin
      do_load = 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// tb/tb_pipeline_stall_ctrl.sv - directed and random checks of pipeline_stall_ctrl against a slot-level model
module tb_pipeline_stall_ctrl;

  logic        clk;
  logic        reset, hazard, branch_taken, dmem_busy;
  logic [31:0] IF_pc, IF_order;

  logic        pw[2], bu[2], ho[2], iv[2];
  logic [31:0] ipc[2], iord[2];
  logic [15:0] st0, fl0;
  logic [3:0]  st1, fl1;

  int passed = 0;
  int total  = 0;

  // Model: per instance, remaining squash slots after a branch, plus IF/ID contents and counters
  int          fc[2]   = '{1, 3};
  int          cmax[2] = '{65535, 15};
  logic [31:0] m_pc[2], m_ord[2];
  logic        m_val[2];
  int          m_st[2], m_fl[2], m_left[2];

  pipeline_stall_ctrl #(.FLUSH_CYCLES(1), .CNT_W(16), .NOP_WORD(32'h00000000)) u1 (
    .clk(clk), .reset(reset), .hazard(hazard), .branch_taken(branch_taken),
    .dmem_busy(dmem_busy), .IF_pc(IF_pc), .IF_order(IF_order),
    .PC_write(pw[0]), .IDEX_bubble(bu[0]), .EXMEM_hold(ho[0]),
    .ID_pc(ipc[0]), .ID_order(iord[0]), .ID_valid(iv[0]),
    .stall_count(st0), .flush_count(fl0)
  );

  pipeline_stall_ctrl #(.FLUSH_CYCLES(3), .CNT_W(4), .NOP_WORD(32'h00000000)) u3 (
    .clk(clk), .reset(reset), .hazard(hazard), .branch_taken(branch_taken),
    .dmem_busy(dmem_busy), .IF_pc(IF_pc), .IF_order(IF_order),
    .PC_write(pw[1]), .IDEX_bubble(bu[1]), .EXMEM_hold(ho[1]),
    .ID_pc(ipc[1]), .ID_order(iord[1]), .ID_valid(iv[1]),
    .stall_count(st1), .flush_count(fl1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s[dut%0d] observed=%h expected=%h", tag, k, obs, exp);
  endtask

  function automatic logic [31:0] stall_obs(input int k);
    return (k == 0) ? 32'(st0) : 32'(st1);
  endfunction

  function automatic logic [31:0] flush_obs(input int k);
    return (k == 0) ? 32'(fl0) : 32'(fl1);
  endfunction

  task automatic cyc(input logic r, input logic b, input logic br, input logic hz,
                     input logic [31:0] pc, input logic [31:0] ord);
    logic e_pw, e_bu, e_ho;
    @(negedge clk);
    reset = r; dmem_busy = b; branch_taken = br; hazard = hz;
    IF_pc = pc; IF_order = ord;
    #1;
    for (int k = 0; k < 2; k++) begin
      if (r)                       begin e_pw = 0; e_bu = 1; e_ho = 0; end
      else if (b)                  begin e_pw = 0; e_bu = 0; e_ho = 1; end
      else if (br || m_left[k] > 0) begin e_pw = 1; e_bu = 1; e_ho = 0; end
      else if (hz)                 begin e_pw = 0; e_bu = 1; e_ho = 0; end
      else                         begin e_pw = 1; e_bu = 0; e_ho = 0; end
      chk("PC_write", k, 32'(pw[k]), 32'(e_pw));
      chk("IDEX_bubble", k, 32'(bu[k]), 32'(e_bu));
      chk("EXMEM_hold", k, 32'(ho[k]), 32'(e_ho));
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      if (r) begin
        m_pc[k] = 0; m_ord[k] = 0; m_val[k] = 0; m_st[k] = 0; m_fl[k] = 0; m_left[k] = 0;
      end else if (b) begin
        // frozen: nothing moves
      end else if (br || m_left[k] > 0) begin
        m_pc[k] = 0; m_ord[k] = 0; m_val[k] = 0;
        if (m_fl[k] < cmax[k]) m_fl[k]++;
        m_left[k] = br ? fc[k] - 1 : m_left[k] - 1;
      end else if (hz) begin
        if (m_st[k] < cmax[k]) m_st[k]++;
      end else begin
        m_pc[k] = pc; m_ord[k] = ord; m_val[k] = 1;
      end
      chk("ID_pc", k, ipc[k], m_pc[k]);
      chk("ID_order", k, iord[k], m_ord[k]);
      chk("ID_valid", k, 32'(iv[k]), 32'(m_val[k]));
      chk("stall_count", k, stall_obs(k), m_st[k]);
      chk("flush_count", k, flush_obs(k), m_fl[k]);
    end
  endtask

  initial begin
    reset = 1; hazard = 0; branch_taken = 0; dmem_busy = 0;
    IF_pc = 0; IF_order = 0;
    for (int k = 0; k < 2; k++) begin
      m_pc[k] = 0; m_ord[k] = 0; m_val[k] = 0; m_st[k] = 0; m_fl[k] = 0; m_left[k] = 0;
    end

    // reset held two cycles, then first word loads
    cyc(1, 0, 0, 0, 32'h4, 32'h8C220004);
    cyc(1, 0, 0, 0, 32'h4, 32'h8C220004);
    chk("reset_order", 0, iord[0], 32'h0);
    chk("reset_valid", 0, 32'(iv[0]), 32'h0);
    cyc(0, 0, 0, 0, 32'h104, 32'h8C220004);
    chk("first_order", 0, iord[0], 32'h8C220004);
    chk("first_pc", 0, ipc[0], 32'h104);

    // load-use stall holds IF/ID for one edge
    cyc(0, 0, 0, 0, 32'h108, 32'h00412020);
    cyc(0, 0, 0, 1, 32'h10C, 32'h8C230008);
    chk("stall_hold", 0, iord[0], 32'h00412020);
    chk("stall_cnt1", 0, 32'(st0), 32'h1);
    cyc(0, 0, 0, 0, 32'h10C, 32'h8C230008);

    // branch and hazard together: branch wins
    cyc(0, 0, 1, 1, 32'h110, 32'hAC240000);
    chk("br_flush_cnt", 0, 32'(fl0), 32'h1);
    chk("br_stall_cnt", 0, 32'(st0), 32'h1);
    cyc(0, 0, 0, 0, 32'h200, 32'h20010001);

    // three-slot squash, then back-to-back branches
    cyc(0, 0, 1, 0, 32'h204, 32'h20020002);
    cyc(0, 0, 0, 0, 32'h208, 32'h20030003);
    cyc(0, 0, 0, 0, 32'h20C, 32'h20040004);
    cyc(0, 0, 0, 0, 32'h210, 32'h20050005);
    chk("fc3_resume", 1, 32'(iv[1]), 32'h1);
    cyc(0, 0, 1, 0, 32'h214, 32'h20060006);
    cyc(0, 0, 1, 0, 32'h218, 32'h20070007);
    cyc(0, 0, 0, 0, 32'h21C, 32'h20080008);
    cyc(0, 0, 0, 0, 32'h220, 32'h20090009);
    chk("fc3_extend_valid", 1, 32'(iv[1]), 32'h0);
    cyc(0, 0, 0, 0, 32'h224, 32'h200A000A);

    // dmem freeze overrides hazard
    for (int i = 0; i < 4; i++) cyc(0, 1, 0, 1, 32'h300, 32'h8C2B0000);
    cyc(0, 0, 0, 0, 32'h304, 32'h8C2C0000);

    // counter saturation on the 4-bit instance
    for (int i = 0; i < 20; i++) cyc(0, 0, 0, 1, 32'h308, 32'h8C2D0000);
    chk("stall_sat", 1, 32'(st1), 32'hF);
    for (int i = 0; i < 20; i++) cyc(0, 0, 1, 0, 32'h30C, 32'h8C2E0000);
    chk("flush_sat", 1, 32'(fl1), 32'hF);

    // randomized mix
    for (int i = 0; i < 600; i++) begin
      cyc(($urandom_range(49) == 0), ($urandom_range(5) == 0), ($urandom_range(7) == 0),
          ($urandom_range(2) == 0), $urandom, $urandom);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
